// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared state encoding, default timeout and alignment helper for mem_if
package mem_if_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int TIMEOUT_DEF = 16;
  function automatic logic aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction
endpackage

// File: rtl/mem_wdog.sv
// mem_wdog: BUSY wait counter, expired flags the cycle the count would reach TIMEOUT
module mem_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign expired = en && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_if.sv
// mem_if: multicycle CPU memory access sequencer with alignment check and ack timeout
module mem_if
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_ifetch,
  input  logic        IorD,
  input  logic [31:0] pc,
  input  logic [31:0] aluout,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  state_t state, state_nx;
  logic [31:0] addr;
  logic accept, misal, ack, tmo, err_q, if_q;
  mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clear(state != BUSY),
    .en(state == BUSY && !mem_ack),
    .expired(tmo)
  );
  always_comb begin
    addr = IorD ? aluout : pc;
    accept = state == IDLE && cpu_req && aligned(addr[1:0]);
    misal = state == IDLE && cpu_req && !aligned(addr[1:0]);
    ack = state == BUSY && mem_ack;
    state_nx = state == DONE ? IDLE : (misal || ack || tmo) ? DONE : accept ? BUSY : state;
  end
  assign busy = state == BUSY || (state == IDLE && cpu_req);
  assign done = state == DONE;
  assign err = state == DONE && err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ir <= '0;
      mdr <= '0;
      err_q <= 1'b0;
      if_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_req <= 1'b1;
        mem_we <= cpu_we;
        mem_addr <= addr;
        mem_wdata <= wdata;
        if_q <= cpu_ifetch;
      end else if (ack || tmo) begin
        mem_req <= 1'b0;
        mem_we <= 1'b0;
      end
      if (ack && !mem_we && if_q) ir <= mem_rdata;
      if (ack && !mem_we && !if_q) mdr <= mem_rdata;
      if (misal || ack || tmo) err_q <= misal || tmo;
    end
  end
endmodule

// File: doc/mem_if.md
MEM_IF -- requirements
Module: mem_if

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max mem_ack wait cycles in BUSY before abort.
REQ-002 SHALL have ports (name  direction  width  meaning); reset rst, asynchronous, active-high; clock clk:
  clk  in  1  clock, rising edge
  rst  in  1  asynchronous, active-high reset
  cpu_req  in  1  access request from controller (IF or MEM state)
  cpu_we  in  1  1 = store (MemWrite), 0 = load
  cpu_ifetch  in  1  1 = instruction fetch (IRWrite), load into ir
  IorD  in  1  address select: 0 = pc, 1 = aluout
  pc  in  32  program counter
  aluout  in  32  ALU result register (data address)
  wdata  in  32  store data (ReadData2)
  busy  out  1  access in progress; controller holds its state
  done  out  1  one-cycle completion pulse
  err  out  1  one-cycle error pulse (misaligned or timeout), coincident with done
  ir  out  32  instruction register
  mdr  out  32  memory data register
  mem_req  out  1  memory request, registered
  mem_we  out  1  memory write enable, registered
  mem_addr  out  32  word-aligned memory address, registered
  mem_wdata  out  32  memory write data, registered
  mem_ack  in  1  memory completion
  mem_rdata  in  32  memory read data, valid with mem_ack

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-004 IDLE: cpu_req=1 with selected address bits [1:0]=00 SHALL latch address (IorD ? aluout : pc), cpu_we, cpu_ifetch, wdata, then go to BUSY.
REQ-005 IDLE: cpu_req=1 with address bits [1:0]!=00 SHALL go to DONE with err flag set; no mem_req issued; ir/mdr unchanged.
REQ-006 BUSY: mem_req=1; mem_we/mem_addr/mem_wdata SHALL be held stable until mem_ack.
REQ-007 BUSY with mem_ack=1: read with ifetch SHALL load ir<=mem_rdata; read without ifetch SHALL load mdr<=mem_rdata; write loads neither; next state DONE.
REQ-008 BUSY wait counter SHALL reset on entry and increment each cycle without ack; on reaching TIMEOUT without ack -> DONE with err set, mem_req dropped, no register load.
REQ-009 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-010 DONE: done=1 and err=latched error flag for exactly one cycle, then IDLE.
REQ-011 busy SHALL be 1 in BUSY and in IDLE when cpu_req=1; 0 in DONE and idle IDLE.
REQ-012 cpu_req SHALL be ignored in BUSY and DONE; a new request is accepted only in IDLE.
REQ-013 Latency: request in cycle 0, mem_req in cycle 1; ack in cycle k gives done in cycle k+1; minimum 3 cycles request-to-IDLE.
REQ-014 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-015 rst SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ir=0, mdr=0, counter=0, error flag=0.
REQ-016 rst during BUSY SHALL abandon the access with no done pulse and no register load.

Structure
REQ-017 State encoding and the default TIMEOUT SHALL live in a shared package mem_if_pkg.
REQ-018 The wait counter SHALL be a sub-module mem_wdog (clear, enable, expired output) of width clog2(TIMEOUT+1).

Verification
REQ-019 Fetch: cpu_req=1, ifetch=1, IorD=0, pc=0x0000_0010; ack in 2nd BUSY cycle with rdata=0x2008_0005 -> mem_addr=0x10, ir=0x2008_0005, done in cycle 3, err=0.
REQ-020 Load: IorD=1, aluout=0x0000_0104; ack in 1st BUSY cycle, rdata=0xDEAD_BEEF -> mdr=0xDEAD_BEEF, ir unchanged, done in cycle 2.
REQ-021 Store: cpu_we=1, aluout=0x20, wdata=0x1234_5678 -> mem_we=1, mem_wdata=0x1234_5678 stable until ack; ir and mdr unchanged.
REQ-022 Misaligned: IorD=1, aluout=0x0000_0102 -> no mem_req, done=err=1 in cycle 1.
REQ-023 Timeout: no ack, TIMEOUT=16 -> mem_req high 16 cycles, then done=err=1; ack on 16th cycle instead -> err=0, data loaded.
REQ-024 Reset mid-BUSY: assert rst in 3rd BUSY cycle -> mem_req=0 same cycle, ir=mdr=0, no done after release.
